// File: rtl/sobel_sequencer_if.sv
// Handshake bundle between the frame sequencer and its neighbours:
// move_control, the Sobel compute unit and the 3x3 window buffer.
interface sobel_sequencer_if;
    logic       start;
    logic       load_done;
    logic       all_done;
    logic       calc_done;
    logic       load_initial;
    logic       start_9_read;
    logic       start_i_read;
    logic       start_write;
    logic       start_move;
    logic       capture_en;
    logic [3:0] capture_idx;
    logic       capture_mode;
    logic       calc_start;
    logic       busy;
    logic       frame_done;
    logic       error;

    // Sequencer side
    modport master (
        input  start, load_done, all_done, calc_done,
        output load_initial, start_9_read, start_i_read, start_write, start_move,
        output capture_en, capture_idx, capture_mode, calc_start,
        output busy, frame_done, error
    );

    // Environment side (move_control, Sobel unit, window buffer, host)
    modport slave (
        output start, load_done, all_done, calc_done,
        input  load_initial, start_9_read, start_i_read, start_write, start_move,
        input  capture_en, capture_idx, capture_mode, calc_start,
        input  busy, frame_done, error
    );
endinterface

// File: rtl/sobel_sequencer.sv
// Frame-level controller: loads the initial addresses, fetches the first
// 3x3 window, then loops compute -> write -> move -> column refill until
// move_control reports the last output pixel. Every output is a register
// written together with the state, so outputs are glitch-free Moore signals.
module sobel_sequencer #(
    parameter int MEM_LAT      = 1,
    parameter int CALC_TIMEOUT = 64,
    parameter int TW           = 7
) (
    input  logic              clk,
    input  logic              n_reset,
    sobel_sequencer_if.master bus
);
    // A read phase keeps its start_* high for 2 cycles per address step;
    // the final step rewinds move_control, so it yields no capture.
    localparam int READ9_LEN = 20;
    localparam int READ4_LEN = 8;
    // Phase ends once the strobe has finished and the last capture has issued.
    localparam int READ9_END = (18 + MEM_LAT > READ9_LEN) ? (18 + MEM_LAT) : READ9_LEN;
    localparam int READ4_END = (6 + MEM_LAT > READ4_LEN) ? (6 + MEM_LAT) : READ4_LEN;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD      = 4'd1,
        WAIT_LOAD = 4'd2,
        READ9     = 4'd3,
        CALC      = 4'd4,
        WAIT_CALC = 4'd5,
        WRITE     = 4'd6,
        MOVE      = 4'd7,
        MOVE_CHK  = 4'd8,
        READ4     = 4'd9,
        DONE      = 4'd10,
        ERR       = 4'd11
    } state_t;

    state_t        state_r;
    logic [TW-1:0] cnt_r;
    logic          load_initial_r;
    logic          start_9_read_r;
    logic          start_i_read_r;
    logic          start_write_r;
    logic          start_move_r;
    logic          capture_en_r;
    logic [3:0]    capture_idx_r;
    logic          capture_mode_r;
    logic          calc_start_r;
    logic          busy_r;
    logic          frame_done_r;
    logic          error_r;

    logic [TW-1:0] rel_s;
    logic          cap_phase_s;
    logic          cap9_s;
    logic          cap4_s;
    logic [3:0]    cap_idx_s;

    // Decide whether next cycle carries read data: slot k is captured
    // MEM_LAT cycles after its address became valid at phase offset 2k+1.
    always_comb begin
        rel_s       = cnt_r - TW'(MEM_LAT);
        cap_phase_s = 1'b0;
        if (cnt_r >= TW'(MEM_LAT)) begin
            cap_phase_s = ~rel_s[0];
        end else begin
            cap_phase_s = 1'b0;
        end
        cap9_s    = cap_phase_s && (rel_s <= TW'(16));
        cap4_s    = cap_phase_s && (rel_s <= TW'(4));
        cap_idx_s = 4'(rel_s >> 1);
    end

    // Sequencer state machine with phase/timeout counter and registered outputs.
    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            load_initial_r <= 1'b0;
            start_9_read_r <= 1'b0;
            start_i_read_r <= 1'b0;
            start_write_r  <= 1'b0;
            start_move_r   <= 1'b0;
            capture_en_r   <= 1'b0;
            capture_idx_r  <= 4'd0;
            capture_mode_r <= 1'b0;
            calc_start_r   <= 1'b0;
            busy_r         <= 1'b0;
            frame_done_r   <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            // Pulse-style outputs fall unless the target state re-asserts them.
            load_initial_r <= 1'b0;
            start_9_read_r <= 1'b0;
            start_i_read_r <= 1'b0;
            start_write_r  <= 1'b0;
            start_move_r   <= 1'b0;
            capture_en_r   <= 1'b0;
            capture_idx_r  <= 4'd0;
            capture_mode_r <= 1'b0;
            calc_start_r   <= 1'b0;
            frame_done_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r        <= LOAD;
                        load_initial_r <= 1'b1;
                        busy_r         <= 1'b1;
                        error_r        <= 1'b0;
                    end
                end
                LOAD: begin
                    state_r <= WAIT_LOAD;
                end
                WAIT_LOAD: begin
                    if (bus.load_done) begin
                        state_r        <= READ9;
                        cnt_r          <= '0;
                        start_9_read_r <= 1'b1;
                    end
                end
                READ9: begin
                    cnt_r          <= cnt_r + TW'(1);
                    start_9_read_r <= (cnt_r < TW'(READ9_LEN - 1));
                    if (cap9_s) begin
                        capture_en_r  <= 1'b1;
                        capture_idx_r <= cap_idx_s;
                    end
                    if (cnt_r == TW'(READ9_END - 1)) begin
                        state_r      <= CALC;
                        cnt_r        <= '0;
                        calc_start_r <= 1'b1;
                    end
                end
                CALC: begin
                    state_r <= WAIT_CALC;
                    cnt_r   <= '0;
                end
                WAIT_CALC: begin
                    // A result arriving in the last allowed cycle still counts.
                    if (bus.calc_done) begin
                        state_r       <= WRITE;
                        cnt_r         <= '0;
                        start_write_r <= 1'b1;
                    end else if (cnt_r == TW'(CALC_TIMEOUT - 1)) begin
                        state_r <= ERR;
                        cnt_r   <= '0;
                        error_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + TW'(1);
                    end
                end
                WRITE: begin
                    if (cnt_r == '0) begin
                        cnt_r         <= TW'(1);
                        start_write_r <= 1'b1;
                    end else begin
                        state_r      <= MOVE;
                        cnt_r        <= '0;
                        start_move_r <= 1'b1;
                    end
                end
                MOVE: begin
                    state_r <= MOVE_CHK;
                end
                MOVE_CHK: begin
                    if (bus.all_done) begin
                        state_r      <= DONE;
                        frame_done_r <= 1'b1;
                    end else begin
                        state_r        <= READ4;
                        cnt_r          <= '0;
                        start_i_read_r <= 1'b1;
                    end
                end
                READ4: begin
                    cnt_r          <= cnt_r + TW'(1);
                    start_i_read_r <= (cnt_r < TW'(READ4_LEN - 1));
                    if (cap4_s) begin
                        capture_en_r   <= 1'b1;
                        capture_idx_r  <= cap_idx_s;
                        capture_mode_r <= 1'b1;
                    end
                    if (cnt_r == TW'(READ4_END - 1)) begin
                        state_r      <= CALC;
                        cnt_r        <= '0;
                        calc_start_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                ERR: begin
                    if (bus.start) begin
                        state_r        <= LOAD;
                        load_initial_r <= 1'b1;
                        error_r        <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_initial = load_initial_r;
    assign bus.start_9_read = start_9_read_r;
    assign bus.start_i_read = start_i_read_r;
    assign bus.start_write  = start_write_r;
    assign bus.start_move   = start_move_r;
    assign bus.capture_en   = capture_en_r;
    assign bus.capture_idx  = capture_idx_r;
    assign bus.capture_mode = capture_mode_r;
    assign bus.calc_start   = calc_start_r;
    assign bus.busy         = busy_r;
    assign bus.frame_done   = frame_done_r;
    assign bus.error        = error_r;
endmodule

// File: doc/sobel_sequencer.md
Name: sobel_sequencer

Overview:
Frame-level controller that sequences the window address generator (move_control) and the Sobel compute unit for one image.
On a start pulse it:
- loads the initial addresses;
- fetches the first 3x3 window;
- then loops compute -> write -> move -> column refill until the address generator reports all_done.

It also tells the window buffer when each read datum is valid and which slot it fills.

Parameters:
MEM_LAT, 1, SRAM read latency in cycles from address-register update to data valid (1..4).
CALC_TIMEOUT, 64, max cycles to wait for calc_done before flagging error (>=2).
TW, 7, width of the timeout/phase counter.

Ports:
clk  in  1  system clock, rising edge.
n_reset  in  1  asynchronous reset, active-high (1 = reset).
start  in  1  single-cycle frame start request; ignored unless idle.
load_done  in  1  from move_control: initial load complete.
all_done  in  1  from move_control: last output pixel written.
calc_done  in  1  single-cycle pulse from the Sobel unit: result ready.
load_initial  out  1  to move_control.
start_9_read  out  1  to move_control.
start_i_read  out  1  to move_control.
start_write  out  1  to move_control.
start_move  out  1  to move_control.
capture_en  out  1  window buffer: sample read data this cycle.
capture_idx  out  4  slot index, 0..8 in full mode, 0..2 in column mode.
capture_mode  out  1  0 = full-window fill, 1 = column refill (buffer shifts first).
calc_start  out  1  single-cycle pulse to the Sobel unit.
busy  out  1  high in every state except IDLE.
frame_done  out  1  single-cycle pulse at frame end.
error  out  1  sticky calc timeout flag; cleared by the next accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-frame aborts immediately with no completion pulse.
- All outputs are registered, Moore-style, driven from state and counters.
- Step rule: move_control performs one address step per two consecutive cycles of a held start_* signal. An N-step operation therefore holds its start_* high for exactly 2N cycles, which leaves move_control's internal done flag cleared.
- IDLE:
  - start=1 -> LOAD. Clears error.
- LOAD: load_initial=1 for 1 cycle -> WAIT_LOAD.
- WAIT_LOAD: wait for load_done=1 -> READ9. No timeout.
- READ9:
  - start_9_read=1 for 20 cycles (10 steps: 9 addresses plus the rewind step).
  - Let offset 0 be the first cycle of READ9. The address for slot k (0..8) is valid at offset 2k+1.
  - capture_en=1 with capture_idx=k and capture_mode=0 at offset 2k+1+MEM_LAT.
  - After 20 cycles, wait until all pending captures have issued -> CALC.
- CALC:
  - calc_start=1 for 1 cycle, then WAIT_CALC.
- WAIT_CALC:
  - calc_done=1 -> WRITE.
  - CALC_TIMEOUT cycles without calc_done -> ERR. calc_done in the timeout cycle wins.
- WRITE: start_write=1 for 2 cycles -> MOVE.
- MOVE: start_move=1 for 1 cycle -> MOVE_CHK.
- MOVE_CHK: one cycle to sample the registered all_done.
  - all_done=1 -> DONE.
  - else -> READ4.
- READ4:
  - start_i_read=1 for 8 cycles (4 steps: 3 new column pixels plus the rewind step).
  - capture_en=1 with capture_idx=j (0..2) and capture_mode=1 at offset 2j+1+MEM_LAT.
  - After draining captures -> CALC.
- DONE: frame_done=1 for 1 cycle -> IDLE.
- ERR: error=1, all start_* outputs 0, busy=1 until the next start (-> LOAD, error cleared).
- Other rules:
  - start while busy is ignored.
  - At most one start_* output is high in any cycle.
  - capture_en never overlaps calc_start.
  - all_done asserting outside MOVE_CHK is ignored until MOVE_CHK.

Test Plan:
1. Reset, MEM_LAT=1, start at cycle 0, load_done 2 cycles after load_initial -> start_9_read high exactly 20 cycles; capture_en at READ9 offsets 2,4,...,18 with idx 0..8; then calc_start pulse.
2. Full frame with all_done forced on the 3rd MOVE_CHK, calc_done 3 cycles after each calc_start -> 3 write/move pairs, 2 READ4 phases of 8 cycles each with idx 0,1,2 and mode 1, one frame_done, busy falls the same cycle frame_done drops.
3. calc_done withheld, CALC_TIMEOUT=64 -> error=1 at the 64th WAIT_CALC cycle, no start_write; a new start clears error and asserts load_initial the next cycle.
4. MEM_LAT=3 -> captures shift to offsets 4,6,...,20; the CALC transition waits for the final capture at offset 20.
5. start pulsed during READ9 and WAIT_CALC -> no effect on sequence or counters.
6. Reset asserted mid-READ4 -> all outputs 0 next edge; no frame_done; a clean restart with start works.
